// File: rtl/conv_window_feeder.sv
// Raster-order pixel stream to 3x3 window stream. Two line buffers hold the
// previous rows; each window is presented on a 72-bit word with valid/ready.
module conv_window_feeder #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [71:0] scope,
    output logic        scope_valid,
    input  logic        scope_ready,
    output logic        scope_last
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO = CW'(2);
    localparam logic [RW-1:0] ROW_TWO = RW'(2);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [7:0]    line1 [IMG_W];
    logic [7:0]    line2 [IMG_W];
    logic [7:0]    hist  [3][2];
    logic [7:0]    new_col [3];
    logic [71:0]   next_scope;
    logic          accept;
    logic          emit;

    assign pix_ready = !scope_valid || scope_ready;
    assign accept    = pix_valid && pix_ready;
    assign emit      = accept && (row >= ROW_TWO) && (col >= COL_TWO);

    // Window columns 0..1 come from history; column 2 is the column arriving now.
    always_comb begin
        new_col[0] = line2[col];
        new_col[1] = line1[col];
        new_col[2] = pix_in;
        next_scope = '0;
        for (int r = 0; r < 3; r++) begin
            next_scope[24*r +: 8]      = hist[r][0];
            next_scope[24*r + 8 +: 8]  = hist[r][1];
            next_scope[24*r + 16 +: 8] = new_col[r];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            line2[col] <= line1[col];
            line1[col] <= pix_in;
            for (int r = 0; r < 3; r++) begin
                hist[r][0] <= hist[r][1];
                hist[r][1] <= new_col[r];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col         <= '0;
            row         <= '0;
            scope       <= '0;
            scope_valid <= 1'b0;
            scope_last  <= 1'b0;
        end else begin
            if (accept) begin
                if (col == COL_MAX) begin
                    col <= '0;
                    row <= (row == ROW_MAX) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            // A new load wins over consumption so back-to-back windows have no bubble.
            if (emit) begin
                scope       <= next_scope;
                scope_valid <= 1'b1;
                scope_last  <= (row == ROW_MAX) && (col == COL_MAX);
            end else if (scope_ready) begin
                scope_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: a 4x4 instance for directed cases and a
// default 8x8 instance, both checked every cycle against an image-based model.
module tb_conv_window_feeder;

    logic        clk = 1'b0;
    logic        rst         [2];
    logic [7:0]  pix_in      [2];
    logic        pix_valid   [2];
    logic        pix_ready   [2];
    logic [71:0] scope       [2];
    logic        scope_valid [2];
    logic        scope_ready [2];
    logic        scope_last  [2];

    always #5 clk = ~clk;

    conv_window_feeder #(.IMG_W(4), .IMG_H(4)) dut_small (
        .clk(clk), .rst(rst[0]), .pix_in(pix_in[0]), .pix_valid(pix_valid[0]),
        .pix_ready(pix_ready[0]), .scope(scope[0]), .scope_valid(scope_valid[0]),
        .scope_ready(scope_ready[0]), .scope_last(scope_last[0])
    );

    conv_window_feeder dut_dflt (
        .clk(clk), .rst(rst[1]), .pix_in(pix_in[1]), .pix_valid(pix_valid[1]),
        .pix_ready(pix_ready[1]), .scope(scope[1]), .scope_valid(scope_valid[1]),
        .scope_ready(scope_ready[1]), .scope_last(scope_last[1])
    );

    typedef struct {
        logic [71:0] s;
        logic        l;
    } win_t;

    int          checks   = 0;
    int          failures = 0;
    int          pos      [2];
    int          win_cnt  [2];
    int          last_cnt [2];
    int          stall_cnt[2];
    logic        acc      [2];
    logic [7:0]  img      [2][8][8];
    win_t        q0[$];
    win_t        q1[$];
    logic [71:0] log_s[$];
    logic        log_l[$];
    logic [71:0] exp4 [4];

    task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int dim(input int k);
        return (k == 0) ? 4 : 8;
    endfunction

    // Model: remember the frame as an image and cut the window out of it by position.
    task automatic monitor(input int k);
        win_t        e;
        logic        has;
        logic [71:0] wv;
        int          w, r, c;
        acc[k] = 1'b0;
        w = dim(k);
        if (!rst[k]) begin
            check("reset_scope", 73'(scope[k]), 73'(0));
            check("reset_valid", 73'(scope_valid[k]), 73'(0));
            check("reset_last", 73'(scope_last[k]), 73'(0));
            check("reset_pix_ready", 73'(pix_ready[k]), 73'(1));
            if (k == 0) q0.delete(); else q1.delete();
            pos[k] = 0;
            return;
        end
        check("pix_ready_rule", 73'(pix_ready[k]), 73'(!scope_valid[k] || scope_ready[k]));
        has = (k == 0) ? (q0.size() != 0) : (q1.size() != 0);
        check("valid_vs_model", 73'(scope_valid[k]), 73'(has));
        if (scope_valid[k] && has) begin
            e = (k == 0) ? q0[0] : q1[0];
            check("scope", 73'(scope[k]), 73'(e.s));
            check("scope_last", 73'(scope_last[k]), 73'(e.l));
            if (!scope_ready[k]) stall_cnt[k]++;
            if (scope_ready[k]) begin
                if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                win_cnt[k]++;
                if (scope_last[k]) last_cnt[k]++;
                if (k == 0) begin
                    log_s.push_back(scope[k]);
                    log_l.push_back(scope_last[k]);
                end
            end
        end
        if (pix_valid[k] && pix_ready[k]) begin
            acc[k] = 1'b1;
            r = pos[k] / w;
            c = pos[k] % w;
            img[k][r][c] = pix_in[k];
            if (r >= 2 && c >= 2) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        wv[8*(3*i+j) +: 8] = img[k][r-2+i][c-2+j];
                e.s = wv;
                e.l = (r == w - 1) && (c == w - 1);
                if (k == 0) q0.push_back(e); else q1.push_back(e);
            end
            pos[k] = (pos[k] + 1) % (w * w);
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor(0);
        monitor(1);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log(input int k);
        log_s.delete();
        log_l.delete();
        win_cnt[k]   = 0;
        last_cnt[k]  = 0;
        stall_cnt[k] = 0;
    endtask

    task automatic do_reset(input int k);
        rst[k] = 1'b0;
        repeat (3) step();
        rst[k] = 1'b1;
    endtask

    // bp: 0 = always ready, 1 = random ready, 2 = stall the first window 5 cycles
    task automatic stream(input int k, input int start, input int n, input bit gaps,
                          input int bp, input bit rndval);
        int sent   = 0;
        int budget = 0;
        while (sent < n && budget < 4000) begin
            pix_in[k]    = rndval ? 8'($urandom) : 8'(start + sent);
            pix_valid[k] = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            case (bp)
                0:       scope_ready[k] = 1'b1;
                1:       scope_ready[k] = ($urandom_range(0, 3) != 0);
                default: scope_ready[k] = (stall_cnt[k] >= 5);
            endcase
            step();
            if (acc[k]) sent++;
            budget++;
        end
        if (sent < n) check("stream_progress", 73'(sent), 73'(n));
        pix_valid[k] = 1'b0;
    endtask

    task automatic drain(input int k);
        int left;
        pix_valid[k]   = 1'b0;
        scope_ready[k] = 1'b1;
        repeat (4) step();
        left = (k == 0) ? q0.size() : q1.size();
        check("drain_empty", 73'(left), 73'(0));
    endtask

    task automatic check_4x4();
        check("win_count_4x4", 73'(win_cnt[0]), 73'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < log_s.size()) begin
                check("win_literal", 73'(log_s[i]), 73'(exp4[i]));
                check("last_literal", 73'(log_l[i]), 73'(i == 3));
            end
        end
    endtask

    initial begin
        exp4[0] = 72'h0B0A09070605030201;
        exp4[1] = 72'h0C0B0A080706040302;
        exp4[2] = 72'h0F0E0D0B0A09070605;
        exp4[3] = 72'h100F0E0C0B0A080706;
        for (int k = 0; k < 2; k++) begin
            rst[k]         = 1'b0;
            pix_in[k]      = 8'h00;
            pix_valid[k]   = 1'b0;
            scope_ready[k] = 1'b1;
            pos[k]         = 0;
            win_cnt[k]     = 0;
            last_cnt[k]    = 0;
            stall_cnt[k]   = 0;
        end
        repeat (2) step();
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        step();

        // first window, continuous stream
        clear_log(0);
        stream(0, 1, 16, 1'b0, 0, 1'b0);
        drain(0);
        check_4x4();

        // backpressure on the first window
        do_reset(0);
        clear_log(0);
        stream(0, 1, 16, 1'b0, 2, 1'b0);
        drain(0);
        check("stall_cycles", 73'(stall_cnt[0]), 73'(5));
        check_4x4();

        // random input gaps
        do_reset(0);
        clear_log(0);
        stream(0, 1, 16, 1'b1, 0, 1'b0);
        drain(0);
        check_4x4();

        // back-to-back frames
        do_reset(0);
        clear_log(0);
        stream(0, 1, 32, 1'b0, 0, 1'b0);
        drain(0);
        check("win_count_2frames", 73'(win_cnt[0]), 73'(8));
        check("last_count_2frames", 73'(last_cnt[0]), 73'(2));
        if (log_s.size() > 4)
            check("frame2_first_win", 73'(log_s[4]), 73'(72'h1B1A19171615131211));

        // reset in the middle of a frame
        clear_log(0);
        stream(0, 1, 10, 1'b0, 0, 1'b0);
        do_reset(0);
        clear_log(0);
        stream(0, 1, 16, 1'b0, 0, 1'b0);
        drain(0);
        check_4x4();

        // random data, gaps and backpressure over three frames
        do_reset(0);
        clear_log(0);
        stream(0, 0, 48, 1'b1, 1, 1'b1);
        drain(0);
        check("win_count_random", 73'(win_cnt[0]), 73'(12));
        check("last_count_random", 73'(last_cnt[0]), 73'(3));

        // default 8x8 size: pixel = 8*row+col, then random traffic
        clear_log(1);
        stream(1, 0, 64, 1'b0, 0, 1'b0);
        drain(1);
        check("win_count_8x8", 73'(win_cnt[1]), 73'(36));
        check("last_count_8x8", 73'(last_cnt[1]), 73'(1));
        clear_log(1);
        stream(1, 0, 64, 1'b1, 1, 1'b1);
        drain(1);
        check("win_count_8x8_rand", 73'(win_cnt[1]), 73'(36));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_window_feeder.md
# conv_window_feeder

Streams raster-order 8-bit pixels in and produces a 3x3 window on a 72-bit scope word for each valid output position, packed in the element order the convolver consumes. It sits directly upstream of the convolver. It buffers two prior image rows internally, and both its input and output use valid/ready handshakes.

## Interface
- IMG_W, default 8: image width in pixels; must be at least 3.
- IMG_H, default 8: image height in rows; must be at least 3.
- clk  input  1: single clock; all state updates on the rising edge.
- rst  input  1: asynchronous, active-low reset.
- pix_in  input  8: pixel value, unsigned.
- pix_valid  input  1: pix_in is valid this cycle.
- pix_ready  output  1: feeder accepts a pixel this cycle.
- scope  output  72: 3x3 window. Element p occupies bits [8p+7:8p]; p = 3*r + c.
  - r = 0 is the oldest (top) row; c = 0 is the leftmost column.
- scope_valid  output  1: scope holds an unconsumed window.
- scope_ready  input  1: downstream consumes scope this cycle.
- scope_last  output  1: qualifies scope_valid; marks the final window of a frame.

## Operation
- Accept pixel when pix_valid && pix_ready. Nothing changes on cycles without an accept.
- pix_ready = !scope_valid || scope_ready (combinational). This means no pixel is accepted while a window is stalled.
- Position counters:
  - col: 0..IMG_W-1, width $clog2(IMG_W).
  - row: 0..IMG_H-1, width $clog2(IMG_H).
  - col increments per accept and wraps to 0 at IMG_W-1; row increments on that wrap.
  - After the pixel at (IMG_H-1, IMG_W-1), both counters return to 0 and the next frame starts.
- Line storage: two row buffers of IMG_W pixels plus a 3x3 window register.
  - On accept, the window shifts left by one column.
  - The new right column is {row buffer 2 at col, row buffer 1 at col, pix_in}, oldest to newest.
  - The row buffers update at index col.
- Window emission: on an accept at (row, col) with row >= 2 and col >= 2:
  - Load scope with pixels from rows row-2..row and cols col-2..col.
  - Set scope_valid.
  - Set scope_last = (row == IMG_H-1 && col == IMG_W-1).
- Positions with row < 2 or col < 2 produce no window. Windows never wrap across a row boundary.
- scope_valid clears on a handshake (scope_valid && scope_ready) unless a new window loads on the same cycle; in that case it stays 1 with the new data.
- scope and scope_last are held stable while scope_valid && !scope_ready.
- Windows per frame: (IMG_W-2)*(IMG_H-2).
- No arithmetic beyond the counters. Pixel values pass through unmodified.

## Timing
- Reset (rst low, asynchronous): scope = 0, scope_valid = 0, scope_last = 0, col = 0, row = 0.
  - Row buffer contents need not be cleared; they are gated by the row >= 2 condition.
  - pix_ready is 1 immediately after reset.
- Latency: the window appears on scope one clock after the accept of its bottom-right pixel.
- Throughput: one pixel per clock. With scope_ready tied high, one window per clock in the emitting region.
- Simultaneous scope_ready and a new accept: the old window is consumed and the new window is loaded in the same edge, with no bubble.
- Reset mid-frame: the partial frame is discarded and the next accepted pixel is treated as (0,0). Any pending window is dropped.
- A pix_valid gap stalls the counters and window. Output state is unaffected.

## Test plan
- First window:
  - Stimulus: IMG_W=4, IMG_H=4; pixels 1..16 in raster order; scope_ready=1; no gaps.
  - Response: 4 windows.
  - The first window appears one cycle after pixel 11 is accepted, with scope = 72'h0B0A09070605030201.
  - The last window is 72'h100F0E0C0B0A080706 with scope_last = 1; scope_last = 0 on the other three.
- Backpressure:
  - Stimulus: same stream; scope_ready held low 5 cycles after the first window.
  - Response: pix_ready = 0 throughout the stall; scope stays at 72'h0B0A09070605030201; no pixels are lost.
  - Afterwards the remaining 3 windows match the first-window case.
- Input gaps: pix_valid toggled randomly on the 4x4 stream. The four window values and their order match the first-window case.
- Back-to-back frames: two 4x4 frames, the second with pixels 17..32.
  - The first window of the second frame is 72'h1B1A19171615131211.
  - Exactly 8 windows total; exactly 2 have scope_last = 1.
- Mid-frame reset:
  - Stimulus: assert rst after pixel 10 of a 4x4 frame, then send pixels 1..16.
  - Response: all outputs read 0 during reset; afterwards the output is identical to the first-window case.
- Default size: IMG_W=8, IMG_H=8 stream with pixel = 8*row+col. Exactly 36 windows; the scope of each window matches a reference model.
